// File: rtl/tx_stream_arbiter_pkg.sv
// Shared types and constants for the USB-CDC transmit stream arbiter.
// Also used by the bus arbiters that reuse tx_rr_pick.
package tx_stream_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_TAG   = 2'd2
   } arb_state_e;

   localparam logic [7:0] ARB_TAG_BASE_DEFAULT = 8'hF0;

   // Idle counter width; keeps one bit when revocation is disabled so the port stays legal.
   function automatic int cnt_width(input int hold);
      return (hold <= 0) ? 1 : $clog2(hold + 1);
   endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational round-robin selector: first asserted request after i_last, wrapping.
// Shared between the USB-CDC stream arbiter and the VGA/keyboard bus arbiter.
module tx_rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Two passes: indices above the last owner first, then wrap to the low end.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!o_any && i_req[i] && (i > int'(i_last))) begin
            o_any = 1'b1;
            o_idx = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!o_any && i_req[i]) begin
            o_any = 1'b1;
            o_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing the usbcdc transmit byte stream.
// Optional source-tag byte per grant when TX_STREAM_ARB_TAG_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no owner; pick next requester round-robin from last_grant+1
// ARB_TAG   | owner chosen; emit TAG_BASE|grant_id once output reg is free
// ARB_GRANT | owner streams bytes until a last byte or an idle timeout
module tx_stream_arbiter
   import tx_stream_arbiter_pkg::*;
#(
   parameter int         NREQ         = 2,
   parameter int         HOLD_TIMEOUT = 1024,
   parameter logic [7:0] TAG_BASE     = ARB_TAG_BASE_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ*8-1:0]        req_data,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = cnt_width(HOLD_TIMEOUT);

`ifdef TX_STREAM_ARB_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   arb_state_e     r_state;
   arb_state_e     w_state_nxt;
   logic [GW-1:0]  r_grant_id;
   logic [GW-1:0]  r_last_grant;
   logic [CW-1:0]  r_idle_cnt;
   logic [7:0]     r_out_data;
   logic           r_out_valid;

   logic           w_pick_any;
   logic [GW-1:0]  w_pick_idx;
   logic           w_out_free;
   logic           w_own_valid;
   logic           w_own_last;
   logic [7:0]     w_own_data;
   logic           w_xfer;
   logic           w_load_tag;
   logic           w_timeout_hit;
   logic [7:0]     w_tag_byte;

   tx_rr_pick #(
      .N  (NREQ),
      .IW (GW)
   ) u_pick (
      .i_req  (req_valid),
      .i_last (r_last_grant),
      .o_idx  (w_pick_idx),
      .o_any  (w_pick_any)
   );

   assign w_out_free  = !r_out_valid || out_ready;
   assign w_own_valid = req_valid[r_grant_id];
   assign w_own_last  = req_last[r_grant_id];
   assign w_own_data  = req_data[{r_grant_id, 3'b000} +: 8];
   assign w_tag_byte  = TAG_BASE | 8'(r_grant_id);

   // Revoke on the idle cycle that completes HOLD_TIMEOUT consecutive idle cycles.
   assign w_timeout_hit = (HOLD_TIMEOUT != 0) && !w_own_valid
                          && (r_idle_cnt == CW'(HOLD_TIMEOUT - 1));

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_xfer      = 1'b0;
      w_load_tag  = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = TAG_EN ? ARB_TAG : ARB_GRANT;
            end
         end
         ARB_TAG: begin
            if (w_out_free) begin
               w_load_tag  = 1'b1;
               w_state_nxt = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            req_ready[r_grant_id] = w_out_free;
            w_xfer = w_own_valid && w_out_free;
            if (w_xfer && w_own_last) begin
               w_state_nxt = ARB_IDLE;
            end else if (w_timeout_hit) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= GW'(NREQ - 1);
         r_idle_cnt   <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if ((r_state == ARB_IDLE) && w_pick_any) begin
            r_grant_id   <= w_pick_idx;
            r_last_grant <= w_pick_idx;
         end

         if ((r_state != ARB_GRANT) || w_xfer || (w_state_nxt != ARB_GRANT)) begin
            r_idle_cnt <= '0;
         end else if (!w_own_valid && (r_idle_cnt != CW'(HOLD_TIMEOUT))) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end

         // A refill in the same cycle as out_ready keeps out_valid high for 1 byte/cycle.
         if (w_xfer) begin
            r_out_data  <= w_own_data;
            r_out_valid <= 1'b1;
         end else if (w_load_tag) begin
            r_out_data  <= w_tag_byte;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign grant_id  = r_grant_id;
   assign busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter (NREQ=2, HOLD_TIMEOUT=8).
// Expected tag bytes are added when TX_STREAM_ARB_TAG_EN is defined.
module tb_tx_stream_arbiter;

   localparam int NREQ = 2;
   localparam int HOLD = 8;
`ifdef TX_STREAM_ARB_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NREQ*8-1:0] req_data = '0;
   logic [NREQ-1:0]  req_valid = '0;
   logic [NREQ-1:0]  req_last = '0;
   logic [NREQ-1:0]  req_ready;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [0:0]       grant_id;
   logic             busy;

   int n_pass = 0;
   int n_total = 0;
   logic [7:0] exp_q[$];

   tx_stream_arbiter #(
      .NREQ         (NREQ),
      .HOLD_TIMEOUT (HOLD),
      .TAG_BASE     (8'hF0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic push_tag(input int id);
      if (TAG_EN) exp_q.push_back(8'hF0 | 8'(id));
   endtask

   // Monitor: every accepted output byte must match the head of the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL out_unexpected: actual %0h required none", out_data);
            end else begin
               check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic send_byte(input int id, input logic [7:0] d, input logic lst);
      int cyc = 0;
      req_data[id*8 +: 8] = d;
      req_last[id]  = lst;
      req_valid[id] = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready[id]) break;
         cyc++;
         if (cyc > 200) begin
            n_total++;
            $display("FAIL send_timeout: actual no ready required ready on req%0d", id);
            req_valid[id] = 1'b0;
            req_last[id]  = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
   endtask

   task automatic wait_drain();
      int c = 0;
      while ((exp_q.size() != 0 || out_valid) && c < 300) begin
         @(negedge clk);
         c++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idle;
      int c;
      logic [7:0] first_out;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Simple two-byte packet from req0
      push_tag(0);
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      send_byte(0, 8'h41, 1'b0);
      send_byte(0, 8'h42, 1'b1);
      @(negedge clk);
      check("t1_busy_after_last", busy, 0);
      check("t1_grant_id", grant_id, 0);
      check("t1_last_on_out", out_data, 8'h42);
      wait_drain();

      // Both valid from reset: req0 then req1
      do_reset();
      push_tag(0);
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'hA1);
      push_tag(1);
      exp_q.push_back(8'hB0);
      exp_q.push_back(8'hB1);
      fork
         begin send_byte(0, 8'hA0, 1'b0); send_byte(0, 8'hA1, 1'b1); end
         begin send_byte(1, 8'hB0, 1'b0); send_byte(1, 8'hB1, 1'b1); end
      join
      wait_drain();
      check("t2_grant_id_1", grant_id, 1);

      // req0 alone, then both valid: req1 now has priority
      push_tag(0);
      exp_q.push_back(8'hC0);
      send_byte(0, 8'hC0, 1'b1);
      push_tag(1);
      exp_q.push_back(8'hB2);
      push_tag(0);
      exp_q.push_back(8'hA2);
      fork
         send_byte(0, 8'hA2, 1'b1);
         send_byte(1, 8'hB2, 1'b1);
      join
      wait_drain();
      check("t2_grant_id_0", grant_id, 0);

      // Backpressure: out_ready low for 5 cycles mid-packet
      out_ready = 1'b0;
      first_out = TAG_EN ? 8'hF0 : 8'h61;
      push_tag(0);
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h62);
      exp_q.push_back(8'h63);
      fork
         begin
            send_byte(0, 8'h61, 1'b0);
            send_byte(0, 8'h62, 1'b0);
            send_byte(0, 8'h63, 1'b1);
         end
         begin
            c = 0;
            forever begin
               @(negedge clk);
               if (out_valid || c > 50) break;
               c++;
            end
            check("t3_out_valid_seen", out_valid, 1);
            repeat (5) begin
               @(negedge clk);
               check("t3_stall_data", out_data, first_out);
               check("t3_stall_ready", req_ready, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Timeout: req0 idles after one byte, req1 takes over after 8 idle cycles
      do_reset();
      push_tag(0);
      exp_q.push_back(8'h71);
      push_tag(1);
      exp_q.push_back(8'h81);
      fork
         begin
            send_byte(0, 8'h71, 1'b0);
            idle = 0;
            forever begin
               @(negedge clk);
               if (!busy || idle > 50) break;
               idle++;
            end
            check("t4_idle_cycles", idle, HOLD);
         end
         send_byte(1, 8'h81, 1'b1);
      join
      wait_drain();
      check("t4_grant_id", grant_id, 1);

      // Reset with a byte buffered in the output register
      out_ready = 1'b0;
      req_data[7:0] = 8'h91;
      req_last[0]   = 1'b0;
      req_valid[0]  = 1'b1;
      c = 0;
      forever begin
         @(negedge clk);
         if (out_valid || c > 50) break;
         c++;
      end
      check("t5_buffered", out_valid, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("t5_out_valid", out_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_req_ready", req_ready, 0);
      check("t5_grant_id", grant_id, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      push_tag(0);
      exp_q.push_back(8'hD0);
      push_tag(1);
      exp_q.push_back(8'hE0);
      fork
         send_byte(0, 8'hD0, 1'b1);
         send_byte(1, 8'hE0, 1'b1);
      join
      wait_drain();

      // Single-byte packet from req1 (tagged build emits F1 first)
      push_tag(1);
      exp_q.push_back(8'h55);
      send_byte(1, 8'h55, 1'b1);
      wait_drain();
      check("t6_grant_id", grant_id, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
